// File: rtl/mesh_pkg.sv
// Shared mesh router definitions.
//   - DEFAULT_PACKET_WIDTH : default flit width.
//   - Flit field positions : vc bit, x/y direction bits, x/y hop-count fields.
//   - One-hot output-port codes : {pe, s, n, w, e} = bits [4:0].
package mesh_pkg;

  localparam int DEFAULT_PACKET_WIDTH = 64;

  // Flit field positions
  localparam int VC_BIT   = 63;
  localparam int XDIR_BIT = 62;  // 0 = east/cw, 1 = west/ccw
  localparam int YDIR_BIT = 61;  // 0 = north,   1 = south
  localparam int HX_MSB   = 55;
  localparam int HX_LSB   = 52;
  localparam int HY_MSB   = 51;
  localparam int HY_LSB   = 48;
  localparam int HOP_W    = 4;

  typedef logic [4:0] port_t;

  localparam port_t PORT_NONE = 5'b00000;
  localparam port_t PORT_E    = 5'b00001;
  localparam port_t PORT_W    = 5'b00010;
  localparam port_t PORT_N    = 5'b00100;
  localparam port_t PORT_S    = 5'b01000;
  localparam port_t PORT_PE   = 5'b10000;

endpackage

// File: rtl/link_input_channel_if.sv
// Bundle between one inbound link/switch allocator and link_input_channel.
//   polarity            : router polarity, toggles every cycle
//   si / ri / di        : link side, flit offered / room available / flit
//   req_valid/port/flit : request to the switch allocator
//   grant               : allocator accepts the presented head flit
//   err                 : sticky protocol error
// Handshake rules: a flit moves on the link when si=1 and ri=1 in the same
// cycle (and its vc bit matches polarity); a head flit leaves when req_valid=1
// and grant=1 in the same cycle. si without ri, or grant without req_valid,
// transfer nothing.
// modport master : link/allocator side; modport slave : the input channel.
interface link_input_channel_if #(
  parameter int PACKET_WIDTH = 64
);
  logic                    polarity;
  logic                    si;
  logic                    ri;
  logic [PACKET_WIDTH-1:0] di;
  logic                    req_valid;
  logic [4:0]              req_port;
  logic [PACKET_WIDTH-1:0] req_flit;
  logic                    grant;
  logic                    err;

  modport master (
    output polarity, si, di, grant,
    input  ri, req_valid, req_port, req_flit, err
  );

  modport slave (
    input  polarity, si, di, grant,
    output ri, req_valid, req_port, req_flit, err
  );
endinterface

// File: rtl/vc_fifo.sv
// Per-virtual-channel flit FIFO.
//   clk, reset (async, active-low)
//   push/din : write an entry (ignored when full)
//   pop      : drop the head entry (ignored when empty)
//   dout     : head entry (valid only while !empty)
//   full/empty status from pointers carrying one extra wrap bit.
module vc_fifo #(
  parameter int PACKET_WIDTH = 64,
  parameter int VC_DEPTH     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [PACKET_WIDTH-1:0] din,
  input  logic                    pop,
  output logic [PACKET_WIDTH-1:0] dout,
  output logic                    full,
  output logic                    empty
);
  localparam int AW = $clog2(VC_DEPTH);

  logic [PACKET_WIDTH-1:0] r_mem [VC_DEPTH];
  logic [AW:0]             r_wr_ptr;
  logic [AW:0]             r_rd_ptr;
  logic                    w_push;
  logic                    w_pop;

  // Same index with differing wrap bits means the writer is a full lap ahead.
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: contents are only observed while !empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/link_input_channel.sv
// Input buffer terminating one inbound mesh link.
// Two VC FIFOs; polarity picks the fill VC, ~polarity the drain VC, so one
// FIFO is written while the other is read. The drain head is XY-routed:
// x hops first (e/w), then y hops (n/s), then delivered to pe, with the
// consumed hop field decremented in the presented flit.
//   clk, reset (async, active-low)
//   bus (slave): polarity, si, ri, di, req_valid, req_port, req_flit,
//                grant, err
module link_input_channel
  import mesh_pkg::*;
#(
  parameter int PACKET_WIDTH = DEFAULT_PACKET_WIDTH,
  parameter int VC_DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  link_input_channel_if.slave  bus
);

  logic [1:0]              w_full;
  logic [1:0]              w_empty;
  logic [1:0]              w_push;
  logic [1:0]              w_pop;
  logic [PACKET_WIDTH-1:0] w_dout [2];
  logic                    w_ri;
  logic                    w_vc_ok;
  logic                    w_write;
  logic                    w_proto_err;
  logic                    w_req_valid;
  logic                    w_do_pop;
  logic [PACKET_WIDTH-1:0] w_head;
  port_t                   w_req_port;
  logic [PACKET_WIDTH-1:0] w_req_flit;
  logic                    r_err;

  // ---------------- fill side (VC = polarity) ----------------
  assign w_ri        = bus.polarity ? !w_full[1] : !w_full[0];
  assign w_vc_ok     = (bus.di[VC_BIT] == bus.polarity);
  assign w_write     = bus.si && w_ri && w_vc_ok;
  assign w_proto_err = bus.si && (!w_ri || !w_vc_ok);
  assign w_push      = {w_write && bus.polarity, w_write && !bus.polarity};

  // ---------------- drain side (VC = ~polarity) ----------------
  assign w_req_valid = bus.polarity ? !w_empty[0] : !w_empty[1];
  assign w_head      = bus.polarity ? w_dout[0] : w_dout[1];
  assign w_do_pop    = bus.grant && w_req_valid;
  assign w_pop       = {w_do_pop && !bus.polarity, w_do_pop && bus.polarity};

  vc_fifo #(
    .PACKET_WIDTH (PACKET_WIDTH),
    .VC_DEPTH     (VC_DEPTH)
  ) u_vc0 (
    .clk   (clk),
    .reset (reset),
    .push  (w_push[0]),
    .din   (bus.di),
    .pop   (w_pop[0]),
    .dout  (w_dout[0]),
    .full  (w_full[0]),
    .empty (w_empty[0])
  );

  vc_fifo #(
    .PACKET_WIDTH (PACKET_WIDTH),
    .VC_DEPTH     (VC_DEPTH)
  ) u_vc1 (
    .clk   (clk),
    .reset (reset),
    .push  (w_push[1]),
    .din   (bus.di),
    .pop   (w_pop[1]),
    .dout  (w_dout[1]),
    .full  (w_full[1]),
    .empty (w_empty[1])
  );

  // ---------------- XY route on the drain head ----------------
  // Decrement only touches a nonzero field, so the 4-bit hop never wraps.
  always_comb begin
    w_req_port = PORT_NONE;
    w_req_flit = '0;
    if (w_req_valid) begin
      w_req_flit = w_head;
      if (w_head[HX_MSB:HX_LSB] != '0) begin
        w_req_port = w_head[XDIR_BIT] ? PORT_W : PORT_E;
        w_req_flit[HX_MSB:HX_LSB] = w_head[HX_MSB:HX_LSB] - HOP_W'(1);
      end else if (w_head[HY_MSB:HY_LSB] != '0) begin
        w_req_port = w_head[YDIR_BIT] ? PORT_S : PORT_N;
        w_req_flit[HY_MSB:HY_LSB] = w_head[HY_MSB:HY_LSB] - HOP_W'(1);
      end else begin
        w_req_port = PORT_PE;
      end
    end
  end

  // Sticky until reset: dropped flits cannot be recovered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           r_err <= 1'b0;
    else if (w_proto_err) r_err <= 1'b1;
  end

  assign bus.ri        = w_ri;
  assign bus.req_valid = w_req_valid;
  assign bus.req_port  = w_req_port;
  assign bus.req_flit  = w_req_flit;
  assign bus.err       = r_err;

endmodule

// File: doc/link_input_channel.md
# link_input_channel

Polarity-aware input buffer that terminates one inbound link of a mesh router (cw, ccw, sn, ns or PE side). It has one FIFO per virtual channel (even and odd) and performs XY route computation on the head flit of the VC being drained. It presents one decoded output-port request plus a hop-updated flit to the router's switch allocator. The router instantiates five of these, one per input port; the NIC or neighbour router drives the link side.

## Interface
Parameters:
- PACKET_WIDTH, 64, flit width in bits.
- VC_DEPTH, 2, entries per VC FIFO; power of two, ≥ 2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- polarity  in  1  router polarity; toggles every cycle after reset.
- si  in  1  link send-in; flit valid on di.
- ri  out  1  link ready-in; room in the VC selected by polarity.
- di  in  PACKET_WIDTH  link flit.
- req_valid  out  1  head flit of drain VC available.
- req_port  out  5  one-hot requested output {pe, s, n, w, e} = bits [4:0].
- req_flit  out  PACKET_WIDTH  head flit with hop field updated.
- grant  in  1  switch allocator accepts head; pop this cycle.
- err  out  1  sticky protocol error.

## Operation
- Flit fields: [63] vc; [62] x dir (0 = east/cw, 1 = west/ccw); [61] y dir (0 = north, 1 = south); [55:52] x hop count; [51:48] y hop count; remaining bits are payload and pass through unchanged.
- Fill VC = polarity. Drain VC = ~polarity. Fill and drain therefore never target the same FIFO in the same cycle.
- ri = !full[polarity], combinational.
- Write occurs when si=1, ri=1 and di[63]==polarity: push di into VC[polarity].
- Any of the following sets err, which stays set until reset:
  - si=1 with ri=0: flit dropped.
  - si=1 with di[63]!=polarity: flit dropped, no write.
- req_valid = !empty[~polarity].
- Route on head h of VC[~polarity]:
  - If h.hx != 0: port e (dir x = 0) or w (dir x = 1); req_flit.hx = h.hx − 1.
  - Else if h.hy != 0: port n or s by dir y; req_flit.hy = h.hy − 1.
  - Else: port pe; req_flit = h unchanged.
- Hop decrement is 4-bit and only applies to a nonzero field, so it never wraps.
- Pop occurs when grant=1 and req_valid=1. grant with req_valid=0 is ignored (no pop, no err).
- req_port and req_flit are don't-care when req_valid=0; the RTL drives them to 0.

## Timing
- Reset values: ri=1, req_valid=0, req_port=0, req_flit=0, err=0. Both FIFOs empty, pointers 0.
- Reset asserted mid-operation discards all buffered flits immediately (asynchronous). The first write is accepted on the first edge after deassertion.
- Latency: a flit written at the edge of a polarity=p cycle appears on req_* in the next cycle (polarity=~p). Minimum link-to-request latency is 1 cycle.
- req_* are combinational from FIFO head state and polarity. There is no combinational path from si/di to req_*, or from grant to ri.
- Full: with VC_DEPTH entries, ri=0 in that VC's fill cycles until a pop frees an entry. ri rises in the next cycle whose polarity selects that VC.
- Pointers wrap modulo VC_DEPTH. Full/empty is decided by an extra wrap bit on each pointer.
- FIFO order is strict per VC. There is no ordering between the two VCs.

## Structure
- Shared package mesh_pkg holds:
  - PACKET_WIDTH default.
  - Field position constants: VC_BIT, XDIR_BIT, YDIR_BIT, HX_MSB/LSB, HY_MSB/LSB.
  - One-hot port constants: PORT_E, PORT_W, PORT_N, PORT_S, PORT_PE.
- Sub-module vc_fifo (PACKET_WIDTH, VC_DEPTH), instantiated twice, with ports clk, reset, push, din, pop, dout, full, empty.
- Route compute and polarity muxing stay in link_input_channel.

## Test plan
- Reset release with polarity=0, then send si=1, di={vc=0, hx=2, dir x=0}: next cycle req_valid=1, req_port=00001 (e), req_flit.hx=1.
- Flit with hx=0, hy=3, dir y=1 on VC1: req_port=01000 (s), req_flit.hy=2. Flit with hx=hy=0: req_port=10000 (pe), req_flit==di.
- With grant=0, fill VC0 with 2 flits: ri=0 on even cycles. A third si on an even cycle sets err=1 and the flit is lost. Grant once: ri=1 on the following even cycle and order is preserved.
- Send si=1 with di[63]=1 while polarity=0: no write, err=1, req_valid unaffected.
- Interleave flits on both VCs every cycle with grant=1: zero loss, per-VC order is kept, and one request appears per cycle.
- Assert reset with both FIFOs holding flits: ri=1 and req_valid=0 immediately, err=0. After release, the first flit is accepted normally.
